// File: rtl/drum_pipe_mult.sv
// Three-stage pipelined DRUM approximate multiplier with valid/ready handshake.
// Optional macro DRUM_PIPE_SIGNED_EN selects two's-complement operands and result.
module drum_pipe_mult #(
  parameter int WIDTH = 16,
  parameter int K     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] r
);

  localparam int LW = $clog2(WIDTH);
  localparam int SW = $clog2(2*(WIDTH-K)+1);
  localparam int PW = 2*K;
  localparam int RW = 2*WIDTH;

  typedef struct packed {
    logic [K-1:0]  m;
    logic [SW-1:0] s;
  } op_t;

  function automatic logic [LW-1:0] lead_one(input logic [WIDTH-1:0] x);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (x[i]) idx = LW'(i);
    return idx;
  endfunction

  // Operands below 2^K pass through exactly; larger ones keep K bits from the
  // leading one down, with the lowest kept bit forced to 1 to unbias truncation.
  function automatic op_t drum_op(input logic [WIDTH-1:0] x);
    op_t res;
    int  kk;
    kk    = int'(lead_one(x));
    res.m = x[K-1:0];
    res.s = '0;
    if (kk >= K) begin
      res.s = SW'(kk - K + 1);
      res.m = K'(x >> (kk - K + 1)) | K'(1);
    end
    return res;
  endfunction

  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  op_t op_a, op_b;
`ifdef DRUM_PIPE_SIGNED_EN
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sign_in;
  // Negating -2^(WIDTH-1) wraps back to itself, which read unsigned is its magnitude.
  assign mag_a   = a[WIDTH-1] ? -a : a;
  assign mag_b   = b[WIDTH-1] ? -b : b;
  assign sign_in = a[WIDTH-1] ^ b[WIDTH-1];
  assign op_a    = drum_op(mag_a);
  assign op_b    = drum_op(mag_b);
`else
  assign op_a    = drum_op(a);
  assign op_b    = drum_op(b);
`endif

  // Stage 1: mantissa/shift per operand.
  logic v1;
  op_t  op1_a, op1_b;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the previous stage's pre-edge value and the pipeline shifts cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      op1_a <= '0;
      op1_b <= '0;
    end else if (en) begin
      v1    <= in_valid;
      op1_a <= op_a;
      op1_b <= op_b;
    end
  end

  // Stage 2: K x K product and combined shift.
  logic          v2;
  logic [PW-1:0] p2;
  logic [SW-1:0] sh2;
  logic [PW-1:0] prod;
  logic [SW-1:0] sh_sum;

  assign prod   = {{K{1'b0}}, op1_a.m} * {{K{1'b0}}, op1_b.m};
  assign sh_sum = op1_a.s + op1_b.s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      p2  <= '0;
      sh2 <= '0;
    end else if (en) begin
      v2  <= v1;
      p2  <= prod;
      sh2 <= sh_sum;
    end
  end

  // Stage 3: final shift (and optional negation) onto r.
  logic [RW-1:0] r_next;

`ifdef DRUM_PIPE_SIGNED_EN
  logic sign1, sign2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign1 <= 1'b0;
      sign2 <= 1'b0;
    end else if (en) begin
      sign1 <= sign_in;
      sign2 <= sign1;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    r_next = {{(RW-PW){1'b0}}, p2} << sh2;
    if (sign2 && (r_next != '0))
      r_next = -r_next;
  end
`else
  always_comb begin
    r_next = {{(RW-PW){1'b0}}, p2} << sh2;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      r         <= '0;
    end else if (en) begin
      out_valid <= v2;
      r         <= r_next;
    end
  end

endmodule

// File: tb/tb_drum_pipe_mult.sv
// Directed bench for drum_pipe_mult (WIDTH=16, K=4); expected products hand-computed.
// Signed vectors run only when DRUM_PIPE_SIGNED_EN is defined.
module tb_drum_pipe_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] r;

  drum_pipe_mult #(.WIDTH(16), .K(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_xfer   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Results are taken in order; anything arriving with nothing expected is an error.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_result", 64'(out_valid), 64'd0);
      else                   check("result", 64'(r), 64'(exp_q.pop_front()));
      n_xfer++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [31:0] e);
    bit acc;
    int budget;
    budget   = 50;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      budget--;
    end while (!acc && budget > 0);
    if (acc) exp_q.push_back(e);
    else     check("send_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  int base;

  initial begin
    // Reset state
    #2;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_r", 64'(r), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Latency: 100*3 -> 13*3<<3 = 312, valid after the third edge
    out_ready = 1'b1;
    check("lat_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = 16'd100; b = 16'd3;
    exp_q.push_back(32'd312);
    tick();
    in_valid = 1'b0;
    check("lat_edge1_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_edge2_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_edge3_valid", 64'(out_valid), 64'd1);
    check("lat_edge3_r", 64'(r), 64'd312);
    repeat (3) tick();

`ifndef DRUM_PIPE_SIGNED_EN
    // Exact path, saturating inputs, zero operands
    send(16'd15, 16'd15, 32'd225);
    send(16'hFFFF, 16'hFFFF, 32'hE100_0000);
    send(16'hFFFF, 16'h0000, 32'd0);
    send(16'h0000, 16'h1234, 32'd0);
    repeat (5) tick();

    // Back-to-back stream of 8 pairs
    base = n_xfer;
    send(16'd7,     16'd9,      32'd63);
    send(16'd20,    16'd5,      32'd110);
    send(16'd255,   16'd255,    32'd57600);
    send(16'd1000,  16'd2,      32'd1920);
    send(16'd16,    16'd16,     32'd324);
    send(16'h1234,  16'd100,    32'd479232);
    send(16'h8000,  16'h8000,   32'h5100_0000);
    send(16'd1,     16'hFFFF,   32'd61440);
    repeat (6) tick();
    check("stream_count", 64'(n_xfer - base), 64'd8);
    check("stream_drained", 64'(exp_q.size()), 64'd0);
`else
    // Signed: -100*3 = -312; -32768*-1 -> mag 9<<12 = 36864; zero with sign set
    send(16'hFF9C, 16'd3,    32'hFFFF_FEC8);
    send(16'h8000, 16'hFFFF, 32'd36864);
    send(16'h0000, 16'hFFFF, 32'd0);
    send(16'hFFF9, 16'd9,    32'hFFFF_FFC1);
    repeat (6) tick();
    check("signed_drained", 64'(exp_q.size()), 64'd0);
`endif

    // Backpressure: three in flight, output held for five cycles
    out_ready = 1'b0;
    send(16'd7,  16'd9,  32'd63);
    send(16'd20, 16'd5,  32'd110);
    send(16'd16, 16'd16, 32'd324);
    for (int i = 0; i < 5; i++) begin
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_r", 64'(r), 64'd63);
      tick();
    end
    base = n_xfer;
    out_ready = 1'b1;
    repeat (5) tick();
    check("stall_drain_count", 64'(n_xfer - base), 64'd3);
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two results in flight, one of them presented
    out_ready = 1'b0;
    send(16'd7,  16'd9, 32'd63);
    send(16'd20, 16'd5, 32'd110);
    tick();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_r", 64'(r), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    tick();
    rst = 1'b0;
    base = n_xfer;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 16'd4; b = 16'd5;
    exp_q.push_back(32'd20);
    tick();
    in_valid = 1'b0;
    check("post_rst_edge1_valid", 64'(out_valid), 64'd0);
    tick();
    check("post_rst_edge2_valid", 64'(out_valid), 64'd0);
    tick();
    check("post_rst_edge3_valid", 64'(out_valid), 64'd1);
    check("post_rst_r", 64'(r), 64'd20);
    repeat (5) tick();
    check("post_rst_count", 64'(n_xfer - base), 64'd1);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
